// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
// Purpose: groups the input beat (in_valid/in_ready/a/b/cin/sub) and the result
//          beat (out_valid/out_ready/sum/cout/overflow) of one adder instance.
// Modports:
//   master - producer of operands and consumer of results (drives in_valid, a, b,
//            cin, sub, out_ready; observes in_ready, out_valid, sum, cout, overflow)
//   slave  - the adder itself (the opposite directions)
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked, pipelined carry-propagate adder/subtractor
// Purpose: computes a + b + cin (sub=0) or a - b (sub=1) modulo 2^WIDTH. The add
//          is cut into STAGES chunks of CW = WIDTH/STAGES bits; chunk k is added in
//          pipeline stage k using the carry registered by stage k-1. One result per
//          cycle sustained, latency STAGES cycles, global stall on backpressure.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears every stage
//   bus   - pipelined_adder_if.slave:
//           in : in_valid, a, b, cin, sub, out_ready
//           out: in_ready, out_valid, sum, cout, overflow
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] bb;
  logic             c0;

  // Subtraction is a + ~b + 1; cin only matters in add mode.
  assign bb = bus.sub ? ~bus.b : bus.b;
  assign c0 = bus.sub | bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * CW;
    localparam int BREM = WIDTH - LO;  // bb bits not yet consumed on entry to stage k

    logic             v_in;
    logic             ci;
    logic [WIDTH-1:0] sa_in;
    logic [BREM-1:0]  bb_in;
    logic [CW:0]      chunk_sum;
    logic [WIDTH-1:0] sa_d;

    logic             v_q;
    logic             c_q;
    // Bits below LO+CW hold finished sum chunks, bits above still hold operand A.
    logic [WIDTH-1:0] sa_q;

    if (k == 0) begin : g_head
      assign v_in  = bus.in_valid;
      assign ci    = c0;
      assign sa_in = bus.a;
      assign bb_in = bb;
    end else begin : g_link
      assign v_in  = g_stage[k-1].v_q;
      assign ci    = g_stage[k-1].c_q;
      assign sa_in = g_stage[k-1].sa_q;
      assign bb_in = g_stage[k-1].g_skew.bb_q;
    end

    assign chunk_sum = {1'b0, sa_in[LO +: CW]} + {1'b0, bb_in[CW-1:0]} + {{CW{1'b0}}, ci};

    always_comb begin
      sa_d           = sa_in;
      sa_d[LO +: CW] = chunk_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        sa_q <= '0;
      end else if (adv) begin
        v_q  <= v_in;
        c_q  <= chunk_sum[CW];
        sa_q <= sa_d;
      end
    end

    // Only the bb chunks still ahead of this beat travel on.
    if (k < STAGES - 1) begin : g_skew
      logic [BREM-CW-1:0] bb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bb_q <= '0;
        end else if (adv) begin
          bb_q <= bb_in[BREM-1:CW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic c_msb_in;
      logic ov_q;

      // MSB sum bit = a_msb ^ bb_msb ^ carry_into_msb, so the carry into the MSB
      // is recovered from the chunk result without a second adder.
      assign c_msb_in = chunk_sum[CW-1] ^ sa_in[WIDTH-1] ^ bb_in[CW-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (adv) begin
          ov_q <= c_msb_in ^ chunk_sum[CW];
        end
      end
    end
  end

  // Whole pipe advances together; bubbles are not squeezed out.
  assign adv           = ~g_stage[STAGES-1].v_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = g_stage[STAGES-1].sa_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;
  assign bus.overflow  = g_stage[STAGES-1].g_tail.ov_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - testbench for pipelined_adder (8x2, 32x4, 64x1)
module tb_pipelined_adder;
  localparam int NCFG = 3;
  localparam int CFG_W [NCFG] = '{8, 32, 64};
  localparam int CFG_S [NCFG] = '{2, 4, 1};

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        cin;
  logic        sub;

  logic        rdy    [NCFG];
  logic        ovld   [NCFG];
  logic [63:0] sum_o  [NCFG];
  logic        cout_o [NCFG];
  logic        ovf_o  [NCFG];
  int          pend   [NCFG];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference: plain unsigned / signed integer arithmetic on w-bit values.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic sb);
    logic [65:0]        m, ua, ub, ut;
    logic signed [65:0] sa, sbv, st, lim;
    res_t               r;
    m   = (66'd1 << w) - 66'd1;
    ua  = {2'b00, a} & m;
    ub  = {2'b00, b} & m;
    sa  = a[w-1] ? $signed(ua - (m + 66'd1)) : $signed(ua);
    sbv = b[w-1] ? $signed(ub - (m + 66'd1)) : $signed(ub);
    lim = $signed(66'd1 << (w - 1));
    if (sb) begin
      ut     = ua - ub;
      st     = sa - sbv;
      r.cout = (ua >= ub);
    end else begin
      ut     = ua + ub + {65'd0, ci};
      st     = sa + sbv + $signed({65'd0, ci});
      r.cout = (ut > m);
    end
    r.sum = 64'(ut & m);
    r.ovf = (st >= lim) || (st < -lim);
    return r;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = CFG_W[g];

    pipelined_adder_if #(.WIDTH(W)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.a         = a_in[W-1:0];
    assign bus.b         = b_in[W-1:0];
    assign bus.cin       = cin;
    assign bus.sub       = sub;
    assign bus.out_ready = out_ready;

    pipelined_adder #(.WIDTH(W), .STAGES(CFG_S[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign rdy[g]    = bus.in_ready;
    assign ovld[g]   = bus.out_valid;
    assign sum_o[g]  = 64'(bus.sum);
    assign cout_o[g] = bus.cout;
    assign ovf_o[g]  = bus.overflow;

    res_t q[$];
    res_t exp_r;
    int   n_pend = 0;

    assign pend[g] = n_pend;

    // Transfers are decided by the values visible at the negedge before the edge.
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
      end else begin
        if (ovld[g] && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL sb%0d: result with no pending beat, got sum %0h", g, sum_o[g]);
          end else begin
            exp_r = q.pop_front();
            if (sum_o[g] !== exp_r.sum || cout_o[g] !== exp_r.cout || ovf_o[g] !== exp_r.ovf) begin
              errors++;
              $display("FAIL sb%0d: got sum %0h cout %0b ovf %0b, expected sum %0h cout %0b ovf %0b",
                       g, sum_o[g], cout_o[g], ovf_o[g], exp_r.sum, exp_r.cout, exp_r.ovf);
            end
          end
        end
        if (in_valid && rdy[g]) q.push_back(model(W, a_in, b_in, cin, sub));
      end
      n_pend = q.size();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[11];
    int          lat;
    int          bi;
    int          acc;
    int          cyc;
    logic        stale;
    logic [63:0] held;
    res_t        er;

    vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[9]  = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[10] = '{8'h10, 8'h03, 1'b1, 1'b1, 8'h0D, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("reset_out_valid%0d", i), 64'(ovld[i]), 64'd0);
      check($sformatf("reset_in_ready%0d", i), 64'(rdy[i]), 64'd1);
      check($sformatf("reset_sum%0d", i), sum_o[i], 64'd0);
      check($sformatf("reset_cout%0d", i), 64'(cout_o[i]), 64'd0);
      check($sformatf("reset_ovf%0d", i), 64'(ovf_o[i]), 64'd0);
    end

    // Directed vectors, one beat at a time, checking latency and result.
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      a_in = 64'(vecs[i].a); b_in = 64'(vecs[i].b);
      cin = vecs[i].cin; sub = vecs[i].sub; in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 64'(rdy[0]), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!ovld[0] && lat < 8);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_sum", i), sum_o[0], 64'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 64'(cout_o[0]), 64'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 64'(ovf_o[0]), 64'(vecs[i].ovf));
      @(posedge clk); #1;
    end

    // Back-to-back beats 0..31: result j must be on the output in cycle j+2.
    for (int c = 0; c < 35; c++) begin
      if (c < 32) begin
        in_valid = 1'b1;
        a_in = 64'(c); b_in = 64'(c * 7 + 3);
        cin = c[0]; sub = c[1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 32) check($sformatf("b2b%0d_in_ready", c), 64'(rdy[0]), 64'd1);
      check($sformatf("b2b%0d_out_valid", c), 64'(ovld[0]), 64'((c >= 2 && c <= 33) ? 1 : 0));
      if (c >= 2 && c <= 33) begin
        er = model(8, 64'(c - 2), 64'((c - 2) * 7 + 3), c[0] ^ 1'b0 ? 1'b0 : 1'b0, 1'b0);
        bi = c - 2;
        er = model(8, 64'(bi), 64'(bi * 7 + 3), bi[0], bi[1]);
        check($sformatf("b2b%0d_sum", c), sum_o[0], er.sum);
      end
      @(posedge clk); #1;
    end

    // Stall: out_ready low for three cycles mid-stream.
    bi = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 6 && c <= 8);
      in_valid = (bi < 12);
      a_in = {$urandom(), $urandom()}; b_in = {$urandom(), $urandom()};
      cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      @(negedge clk);
      if (in_valid && rdy[0]) bi++;
      if (c == 6) held = sum_o[0];
      if (c >= 6 && c <= 8) begin
        check($sformatf("stall%0d_in_ready", c), 64'(rdy[0]), 64'd0);
        check($sformatf("stall%0d_out_valid", c), 64'(ovld[0]), 64'd1);
      end
      if (c == 7 || c == 8) check($sformatf("stall%0d_sum_held", c), sum_o[0], held);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Reset with two beats in flight.
    in_valid = 1'b1; a_in = 64'h11; b_in = 64'h22; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a_in = 64'h33; b_in = 64'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("midrst_valid_before", 64'(ovld[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("midrst_out_valid%0d", i), 64'(ovld[i]), 64'd0);
      check($sformatf("midrst_sum%0d", i), sum_o[i], 64'd0);
      check($sformatf("midrst_cout%0d", i), 64'(cout_o[i]), 64'd0);
      check($sformatf("midrst_ovf%0d", i), 64'(ovf_o[i]), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ovld[0] || ovld[1] || ovld[2]) stale = 1'b1;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);
    @(posedge clk); #1;

    // Random traffic, all three configurations checked by their scoreboards.
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a_in = {$urandom(), $urandom()}; b_in = {$urandom(), $urandom()};
      case ($urandom_range(7))
        0: a_in = '1;
        1: b_in = '1;
        2: a_in = '0;
        3: b_in = a_in;
        default: ;
      endcase
      cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      @(negedge clk);
      if (in_valid && rdy[0]) acc++;
      cyc++;
      @(posedge clk); #1;
    end
    check("rand_beats_accepted", 64'(acc), 64'd10000);

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("drain_pending%0d", i), 64'(pend[i]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
